// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the single-port video/data RAM: VGA fetch, CPU load/store
// and debug/IO. One access in flight at a time; VGA first, CPU protected from starvation.
module mem_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int CPU_MAXW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(CPU_MAXW + 1);
    localparam logic [CNT_W-1:0] MAXW_C   = CNT_W'(CPU_MAXW);
    localparam logic [1:0]       LAT_LAST = 2'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;
    typedef enum logic [1:0] {G_VGA, G_CPU, G_DBG} grant_t;

    state_t            state_q, state_d;
    grant_t            gnt_q, gnt_d, arb_sel;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        lat_q, lat_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              rr_dbg_q, rr_dbg_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    // rr_dbg_q set means debug holds the round-robin turn
    always_comb begin
        arb_sel = G_DBG;
        if (cpu_req && (starve_q >= MAXW_C)) begin
            arb_sel = G_CPU;
        end else if (vga_req) begin
            arb_sel = G_VGA;
        end else if (cpu_req && (!dbg_req || !rr_dbg_q)) begin
            arb_sel = G_CPU;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        rr_dbg_d    = rr_dbg_q;
        vga_rdata_d = vga_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (!cpu_req) begin
                    starve_d = '0;
                end
                if (vga_req || cpu_req || dbg_req) begin
                    state_d = S_ISSUE;
                    gnt_d   = arb_sel;
                    unique case (arb_sel)
                        G_VGA: begin
                            addr_d  = vga_addr;
                            we_d    = 1'b0;
                            wdata_d = '0;
                        end
                        G_CPU: begin
                            addr_d   = cpu_addr;
                            we_d     = cpu_we;
                            wdata_d  = cpu_wdata;
                            rr_dbg_d = 1'b1;
                            starve_d = '0;
                        end
                        default: begin
                            addr_d   = dbg_addr;
                            we_d     = dbg_we;
                            wdata_d  = dbg_wdata;
                            rr_dbg_d = 1'b0;
                        end
                    endcase
                    if (cpu_req && (arb_sel != G_CPU) && (starve_q < MAXW_C)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_LAST;
                state_d = we_q ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 2'd0) begin
                    unique case (gnt_q)
                        G_VGA:   vga_rdata_d = mem_rdata;
                        G_CPU:   cpu_rdata_d = mem_rdata;
                        default: dbg_rdata_d = mem_rdata;
                    endcase
                    state_d = S_ACK;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= G_VGA;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            lat_q       <= 2'd0;
            starve_q    <= '0;
            rr_dbg_q    <= 1'b0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            rr_dbg_q    <= rr_dbg_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Address stays on the bus for the whole access so multi-cycle RAMs see it stable
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == S_ISSUE) && we_q;

    assign vga_ack   = (state_q == S_ACK) && (gnt_q == G_VGA);
    assign cpu_ack   = (state_q == S_ACK) && (gnt_q == G_CPU);
    assign dbg_ack   = (state_q == S_ACK) && (gnt_q == G_DBG);
    assign vga_rdata = vga_rdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with a 1-cycle RAM,
// one with a 3-cycle RAM, each backed by a small behavioural memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        vga_req, cpu_req, cpu_we, dbg_req, dbg_we;
    logic [14:0] vga_addr, cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        vga_ack, cpu_ack, dbg_ack, mem_we;
    logic [15:0] vga_rdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [14:0] mem_addr;

    logic        dbg3_req;
    logic [14:0] dbg3_addr;
    logic        vga_ack3, cpu_ack3, dbg_ack3, mem_we3;
    logic [15:0] vga_rdata3, cpu_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
    logic [14:0] mem_addr3;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .MEM_LAT(1), .CPU_MAXW(8)) u_dut (
        .clk(clk), .reset(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .MEM_LAT(3), .CPU_MAXW(8)) u_dut3 (
        .clk(clk), .reset(rst),
        .vga_req(1'b0), .vga_addr(15'd0), .vga_ack(vga_ack3), .vga_rdata(vga_rdata3),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(15'd0), .cpu_wdata(16'd0),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .dbg_req(dbg3_req), .dbg_we(1'b0), .dbg_addr(dbg3_addr), .dbg_wdata(16'd0),
        .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
        .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // Behavioural RAMs with a backdoor preload port
    logic [15:0] ram1 [0:32767];
    logic [15:0] ram3 [0:32767];
    logic        bd1_we, bd3_we;
    logic [14:0] bd1_a, bd3_a;
    logic [15:0] bd1_d, bd3_d;
    logic [15:0] rd1, rd3_a, rd3_b, rd3_c;

    always @(posedge clk) begin
        if (bd1_we) ram1[bd1_a] <= bd1_d;
        else if (mem_we) ram1[mem_addr] <= mem_wdata;
        rd1 <= ram1[mem_addr];
    end
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        if (bd3_we) ram3[bd3_a] <= bd3_d;
        else if (mem_we3) ram3[mem_addr3] <= mem_wdata3;
        rd3_a <= ram3[mem_addr3];
        rd3_b <= rd3_a;
        rd3_c <= rd3_b;
    end
    assign mem_rdata3 = rd3_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke1(input logic [14:0] a, input logic [15:0] d);
        bd1_we = 1'b1; bd1_a = a; bd1_d = d;
        tick();
        bd1_we = 1'b0;
    endtask

    task automatic poke3(input logic [14:0] a, input logic [15:0] d);
        bd3_we = 1'b1; bd3_a = a; bd3_d = d;
        tick();
        bd3_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Returns cycles from request to ack (-1 on timeout) and mem_we-high cycle count
    task automatic cpu_access(input logic we, input logic [14:0] a, input logic [15:0] wd,
                              output int cyc, output int wes);
        cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        cyc = 0; wes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
            if (mem_we) wes++;
            if (cpu_ack) break;
        end
        cpu_req = 1'b0;
        if (!cpu_ack) cyc = -1;
    endtask

    task automatic dbg_access(input logic we, input logic [14:0] a, input logic [15:0] wd,
                              output int cyc);
        dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
            if (dbg_ack) break;
        end
        dbg_req = 1'b0;
        if (!dbg_ack) cyc = -1;
    endtask

    initial begin
        int cyc, wes, nv1, nv2, ncpu, ngnt, stray;
        int gseq [4];
        logic done;
        logic [15:0] last_before, first_after;

        rst = 1'b1;
        vga_req = 0; cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0;
        vga_addr = '0; cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
        dbg3_req = 0; dbg3_addr = '0;
        bd1_we = 0; bd1_a = '0; bd1_d = '0; bd3_we = 0; bd3_a = '0; bd3_d = '0;
        tick();
        tick();
        chk("rst_acks", 32'({vga_ack, cpu_ack, dbg_ack, vga_ack3, cpu_ack3, dbg_ack3}), 0);
        chk("rst_mem_we", 32'({mem_we, mem_we3}), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_rdata", 32'(vga_rdata | cpu_rdata | dbg_rdata), 0);
        rst = 1'b0;
        tick();

        // CPU write then read back
        cpu_access(1'b1, 15'h0010, 16'h1234, cyc, wes);
        chk("wr_latency", 32'(cyc), 2);
        chk("wr_mem_we_cycles", 32'(wes), 1);
        tick();
        chk("wr_ack_pulse", 32'(cpu_ack), 0);
        cpu_access(1'b0, 15'h0010, 16'h0000, cyc, wes);
        chk("rd_latency", 32'(cyc), 3);
        chk("rd_data", 32'(cpu_rdata), 32'h1234);
        chk("rd_mem_we_cycles", 32'(wes), 0);
        tick();

        // VGA priority against starvation bound, twice to show the counter clears on grant
        poke1(15'h0100, 16'hA5A5);
        poke1(15'h0020, 16'h5A5A);
        vga_addr = 15'h0100; cpu_we = 1'b0; cpu_addr = 15'h0020;
        vga_req = 1'b1; cpu_req = 1'b1;
        nv1 = 0; nv2 = 0; ncpu = 0;
        for (int i = 0; i < 200 && ncpu < 2; i++) begin
            tick();
            if (vga_ack) begin
                if (ncpu == 0) nv1++;
                else nv2++;
            end
            if (cpu_ack) begin
                ncpu++;
                if (ncpu == 2) begin
                    vga_req = 1'b0; cpu_req = 1'b0;
                end
            end
        end
        vga_req = 1'b0; cpu_req = 1'b0;
        chk("starve_cpu_grants", 32'(ncpu), 2);
        chk("starve_vga_first", 32'(nv1), 8);
        chk("starve_vga_after_clear", 32'(nv2), 8);
        chk("starve_cpu_rdata", 32'(cpu_rdata), 32'h5A5A);
        chk("starve_vga_rdata", 32'(vga_rdata), 32'hA5A5);
        tick();

        // CPU/debug round robin from a freshly reset pointer
        do_reset();
        chk("rst2_rdata", 32'(vga_rdata | cpu_rdata | dbg_rdata), 0);
        poke1(15'h0030, 16'h1111);
        poke1(15'h7FFF, 16'hCAFE);
        cpu_we = 1'b0; cpu_addr = 15'h0030; dbg_we = 1'b0; dbg_addr = 15'h7FFF;
        cpu_req = 1'b1; dbg_req = 1'b1;
        ngnt = 0;
        for (int i = 0; i < 4; i++) gseq[i] = 0;
        for (int i = 0; i < 60 && ngnt < 4; i++) begin
            tick();
            if (cpu_ack || dbg_ack) begin
                gseq[ngnt] = cpu_ack ? 1 : 2;
                ngnt++;
                if (ngnt == 4) begin
                    cpu_req = 1'b0; dbg_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk("rr_grant_count", 32'(ngnt), 4);
        chk("rr_grant0_cpu", 32'(gseq[0]), 1);
        chk("rr_grant1_dbg", 32'(gseq[1]), 2);
        chk("rr_grant2_cpu", 32'(gseq[2]), 1);
        chk("rr_grant3_dbg", 32'(gseq[3]), 2);
        chk("rr_dbg_maxaddr", 32'(dbg_rdata), 32'hCAFE);
        chk("rr_cpu_rdata", 32'(cpu_rdata), 32'h1111);
        tick();
        dbg_access(1'b0, 15'h7FFF, 16'h0000, cyc);
        chk("sole_dbg_latency", 32'(cyc), 3);
        tick();

        // Three-cycle RAM latency on the second instance
        poke3(15'h0005, 16'hBEEF);
        dbg3_addr = 15'h0005; dbg3_req = 1'b1;
        cyc = -1; stray = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_ack3 || vga_ack3 || mem_we3) stray++;
            if (dbg_ack3) begin
                cyc = i;
                break;
            end
        end
        dbg3_req = 1'b0;
        chk("lat3_latency", 32'(cyc), 5);
        chk("lat3_rdata", 32'(dbg_rdata3), 32'hBEEF);
        chk("lat3_other_ports", 32'(stray), 0);
        chk("lat3_other_rdata", 32'(vga_rdata3 | cpu_rdata3), 0);
        tick();

        // Reset while a CPU read sits in its wait state
        cpu_we = 1'b0; cpu_addr = 15'h0010; cpu_req = 1'b1;
        tick();
        tick();
        chk("abort_addr_in_flight", 32'(mem_addr), 32'h0010);
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        chk("abort_no_ack", 32'(cpu_ack), 0);
        chk("abort_mem_we", 32'(mem_we), 0);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        chk("abort_rdata", 32'(vga_rdata | cpu_rdata | dbg_rdata), 0);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ack || vga_ack || dbg_ack) stray++;
        end
        chk("abort_no_late_ack", 32'(stray), 0);
        cpu_access(1'b0, 15'h0010, 16'h0000, cyc, wes);
        chk("after_abort_latency", 32'(cyc), 3);
        chk("after_abort_rdata", 32'(cpu_rdata), 32'h1234);
        tick();

        // CPU write interleaved with VGA reads of the same word
        poke1(15'h0040, 16'h0101);
        vga_addr = 15'h0040; vga_req = 1'b1;
        cpu_we = 1'b1; cpu_addr = 15'h0040; cpu_wdata = 16'h7777; cpu_req = 1'b1;
        done = 1'b0; ncpu = 0; wes = 0;
        last_before = 16'hFFFF; first_after = 16'hFFFF;
        for (int i = 0; i < 150 && !done; i++) begin
            tick();
            if (mem_we) wes++;
            if (vga_ack) begin
                if (ncpu == 0) begin
                    last_before = vga_rdata;
                end else begin
                    first_after = vga_rdata;
                    done = 1'b1;
                    vga_req = 1'b0;
                end
            end
            if (cpu_ack) begin
                ncpu++;
                cpu_req = 1'b0;
            end
        end
        vga_req = 1'b0; cpu_req = 1'b0;
        chk("coh_done", 32'(done), 1);
        chk("coh_old_value", 32'(last_before), 32'h0101);
        chk("coh_new_value", 32'(first_after), 32'h7777);
        chk("coh_mem_we_cycles", 32'(wes), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
